io_port_ctrl: RTL and testbench

//  Memory-mapped I/O controller replacing the bare 0x800 in/out port latches of
//  the single-cycle ARM top. Decodes a 3-register window and buffers CPU writes
//  in a TX FIFO drained by a valid/ready output handshake. Holds one RX byte

---
 rtl/io_port_ctrl.sv | 98 +++++++++
 tb/tb_io_port_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/io_port_ctrl.sv
// Memory-mapped I/O port block: a 3-register window with a TX FIFO drained over
// valid/ready, an RX holding register filled over valid/ready, and a polled STATUS.
module io_port_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h800,
    parameter int          DEPTH     = 4,
    parameter int          WIDTH     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [31:0]      rdata,
    output logic             sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [AW:0]                 wr_ptr_q, rd_ptr_q;
    logic                        tx_ovf_q, rx_valid_q;
    logic [WIDTH-1:0]            rx_data_q;

    // Word offset from the window base; modular subtraction makes addresses
    // below the base wrap to huge offsets, so one compare covers both ends.
    logic [29:0] off;
    assign off = addr[31:2] - BASE_ADDR[31:2];
    assign sel = (off < 30'd3);

    logic hit_dout, hit_din, hit_stat;
    assign hit_dout = (off == 30'd0);
    assign hit_din  = (off == 30'd1);
    assign hit_stat = (off == 30'd2);

    logic empty, full, push, pop, ovf_clr, capture, rx_rd;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push    = wr_en && hit_dout;
    assign pop     = out_valid && out_ready;
    assign ovf_clr = wr_en && hit_stat && wdata[3];
    assign capture = in_valid && in_ready;
    assign rx_rd   = rd_en && hit_din && rx_valid_q;

    assign out_valid = ~empty;
    assign out_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign in_ready  = ~rx_valid_q;

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (off[1:0])
                2'd1:    rdata = {{(32-WIDTH){1'b0}}, rx_data_q};
                2'd2:    rdata = {28'b0, tx_ovf_q, rx_valid_q, empty, full};
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_ovf_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            // A pop frees the slot in the same cycle, so a full FIFO still accepts.
            if (push && (!full || pop)) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata[WIDTH-1:0];
                wr_ptr_q                <= wr_ptr_q + PTR_ONE;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (push && full && !pop)
                tx_ovf_q <= 1'b1;
            else if (ovf_clr)
                tx_ovf_q <= 1'b0;
            if (capture) begin
                rx_data_q  <= in_data;
                rx_valid_q <= 1'b1;
            end else if (rx_rd) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata[31:WIDTH]};
endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl: TX FIFO order/overflow, RX handshake, reset, decode.
module tb_io_port_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, rdata;
    logic        wr_en, rd_en, sel;
    logic [7:0]  out_data, in_data;
    logic        out_valid, out_ready, in_valid, in_ready;

    int total = 0;
    int bad   = 0;

    io_port_ctrl #(.BASE_ADDR(32'h800), .DEPTH(4), .WIDTH(8)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .wr_en(wr_en),
        .rd_en(rd_en), .rdata(rdata), .sel(sel), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic [31:0] exp_v);
        addr = 32'h808;
        #1;
        chk(tag, rdata, exp_v);
    endtask

    initial begin
        reset = 1'b1; addr = '0; wdata = '0; wr_en = 0; rd_en = 0;
        out_ready = 0; in_data = '0; in_valid = 0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
        chk("rst_out_data", {24'b0, out_data}, 32'h0);
        chk_status("rst_status", 32'h2);
        chk("rst_sel", {31'b0, sel}, 32'h1);

        // 1: single write, no fall-through, then pop
        wr(32'h800, 32'hA5);
        chk_status("t1_status", 32'h0);
        chk("t1_out_valid", {31'b0, out_valid}, 32'h1);
        chk("t1_out_data", {24'b0, out_data}, 32'hA5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_popped_valid", {31'b0, out_valid}, 32'h0);
        chk_status("t1_status_empty", 32'h2);

        // 2: overflow on fifth write, drain order, W1C
        for (int i = 1; i <= 5; i++) wr(32'h800, i);
        chk_status("t2_status_full_ovf", 32'h9);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("t2_drain%0d", i), {24'b0, out_data}, i);
            tick();
        end
        out_ready = 1'b0;
        chk_status("t2_status_drained", 32'hA);
        wr(32'h808, 32'h8);
        chk_status("t2_status_w1c", 32'h2);

        // 3: push while full with a simultaneous pop
        for (int i = 1; i <= 4; i++) wr(32'h800, 32'h10 + i);
        chk_status("t3_status_full", 32'h1);
        out_ready = 1'b1;
        wr(32'h800, 32'h15);
        out_ready = 1'b0;
        chk_status("t3_status_still_full", 32'h1);
        out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("t3_drain%0d", i), {24'b0, out_data}, 32'h10 + i);
            tick();
        end
        out_ready = 1'b0;
        chk_status("t3_status_empty", 32'h2);

        // 4: RX capture, no overwrite, read clears
        in_data = 8'h3C; in_valid = 1'b1;
        tick();
        in_data = 8'h55;
        tick();
        in_valid = 1'b0;
        chk("t4_in_ready_low", {31'b0, in_ready}, 32'h0);
        chk_status("t4_status_rx", 32'h6);
        addr = 32'h804; rd_en = 1'b1;
        #1;
        chk("t4_rdata", rdata, 32'h3C);
        tick();
        rd_en = 1'b0;
        chk("t4_in_ready_back", {31'b0, in_ready}, 32'h1);
        addr = 32'h804; rd_en = 1'b1;
        #1;
        chk("t4_stale_read", rdata, 32'h3C);
        tick();
        rd_en = 1'b0;
        chk_status("t4_status_after", 32'h2);

        // 5: reset with 3 entries and rx held, reset beats same-cycle push/capture
        for (int i = 0; i < 3; i++) wr(32'h800, 32'h30 + i);
        in_data = 8'h77; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_status("t5_status_pre", 32'h4);
        reset = 1'b1; addr = 32'h800; wdata = 32'h99; wr_en = 1'b1;
        in_data = 8'h88; in_valid = 1'b1;
        tick();
        reset = 1'b0; wr_en = 1'b0; in_valid = 1'b0;
        chk("t5_out_valid", {31'b0, out_valid}, 32'h0);
        chk("t5_in_ready", {31'b0, in_ready}, 32'h1);
        chk("t5_out_data", {24'b0, out_data}, 32'h0);
        chk_status("t5_status", 32'h2);
        addr = 32'h804;
        #1;
        chk("t5_rx_data", rdata, 32'h0);

        // 6: unmapped neighbours above and below the window
        wr(32'h800, 32'h66);
        addr = 32'h80C; wdata = 32'hFF; wr_en = 1'b1; rd_en = 1'b1;
        #1;
        chk("t6_sel_hi", {31'b0, sel}, 32'h0);
        chk("t6_rdata_hi", rdata, 32'h0);
        tick();
        addr = 32'h7FC;
        #1;
        chk("t6_sel_lo", {31'b0, sel}, 32'h0);
        chk("t6_rdata_lo", rdata, 32'h0);
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk_status("t6_status", 32'h0);
        chk("t6_out_data", {24'b0, out_data}, 32'h66);
        addr = 32'h80B;
        #1;
        chk("t6_low_bits_ignored", rdata, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
